exex_pipe: RTL and testbench

Parametrised multi-stage EX-to-EX pipeline register chain for multicycle execution units (multiplier, divider steps). Carries operands, ROB index and exception vector through `STAGES` registered stages with per-stage valid bits, a ready/valid handshake, back-pressure and ROB-age-based selective flush. It sits between the issue side of a multicycle unit and its writeback/ROB-complete port.

---
 rtl/exex_pkg.sv | 38 +++
 rtl/exex_stage.sv | 46 ++++
 rtl/exex_pipe.sv | 150 +++++++++++++++
 tb/tb_exex_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exex_pkg.sv
// exex_pkg: shared definitions for the EX-to-EX pipeline register chain.
//   - default widths / depth for exex_pipe parameters
//   - exex_entry_t: payload carried by each stage (default widths)
//   - rob_age(): ROB-relative age of an index, wrap-safe for widths up to
//     EXEX_ROB_MAX_W bits
// Optional feature macro used by exex_pipe: EXEX_BUBBLE_COLLAPSE_EN.
package exex_pkg;

  localparam int EXEX_DATA_W    = 32;
  localparam int EXEX_ROB_IDX_W = 4;
  localparam int EXEX_EXC_W     = 3;
  localparam int EXEX_STAGES    = 3;
  localparam int EXEX_ROB_MAX_W = 16;

  typedef struct packed {
    logic [EXEX_DATA_W-1:0]    data_a;
    logic [EXEX_DATA_W-1:0]    data_b;
    logic [EXEX_ROB_IDX_W-1:0] rob_idx;
    logic [EXEX_EXC_W-1:0]     exception_vector;
  } exex_entry_t;

  // Distance of idx from the ROB head, modulo 2^idx_w. Arguments are
  // zero-extended to EXEX_ROB_MAX_W bits by the caller; the mask keeps the
  // subtraction wrapping at the real ROB depth.
  function automatic logic [EXEX_ROB_MAX_W-1:0] rob_age(
    input logic [EXEX_ROB_MAX_W-1:0] idx,
    input logic [EXEX_ROB_MAX_W-1:0] head,
    input int unsigned               idx_w
  );
    logic [EXEX_ROB_MAX_W-1:0] mask;
    mask = '1;
    if (idx_w < EXEX_ROB_MAX_W) begin
      mask = mask >> (EXEX_ROB_MAX_W - idx_w);
    end
    return (idx - head) & mask;
  endfunction

endpackage

// File: rtl/exex_stage.sv
// exex_stage: one register stage of the EX-to-EX chain (valid bit + entry).
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears valid and entry)
//   load        : this stage takes the incoming slot this cycle
//   load_valid  : valid bit of the incoming slot (already flush-filtered)
//   capture     : write in_entry into the data register
//   kill        : clear the held entry when the stage is not loading
//   in_entry    : incoming payload
//   valid, entry: registered stage contents
module exex_stage
  import exex_pkg::*;
#(
  parameter int ENTRY_W = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               load_valid,
  input  logic               capture,
  input  logic               kill,
  input  logic [ENTRY_W-1:0] in_entry,
  output logic               valid,
  output logic [ENTRY_W-1:0] entry
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      entry <= '0;
    end else begin
      // Loading replaces the slot (the old entry has moved on or was empty),
      // otherwise the held entry survives unless it is killed.
      if (load) begin
        valid <= load_valid;
      end else if (kill) begin
        valid <= 1'b0;
      end
      // Data of invalid slots is don't-care, so it is only written when a
      // live incoming entry arrives; it holds otherwise.
      if (capture) begin
        entry <= in_entry;
      end
    end
  end

endmodule

// File: rtl/exex_pipe.sv
// exex_pipe: STAGES-deep EX-to-EX pipeline register chain with ready/valid
// handshake, back-pressure and ROB-age based selective flush.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   in_valid / in_ready           : upstream handshake (in_ready is combinational)
//   in_data_a/b, in_rob_idx,
//   in_exception_vector           : incoming entry
//   out_valid / out_ready         : downstream handshake
//   out_data_a/b, out_rob_idx,
//   out_exception_vector          : entry in the last stage
//   out_has_exception             : any exception bit set on a valid output
//   rob_head                      : oldest ROB index (age reference)
//   flush_valid, flush_rob_idx    : kill entries strictly younger than flush_rob_idx
//   flush_all                     : kill every entry, drop the incoming one
//   occupancy                     : number of valid stages
// Macro EXEX_BUBBLE_COLLAPSE_EN: per-stage ready chain (bubbles collapse under
// output back-pressure). Undefined: whole-chain stall while the output is
// blocked.
module exex_pipe
  import exex_pkg::*;
#(
  parameter int DATA_W    = EXEX_DATA_W,
  parameter int ROB_IDX_W = EXEX_ROB_IDX_W,
  parameter int EXC_W     = EXEX_EXC_W,
  parameter int STAGES    = EXEX_STAGES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data_a,
  input  logic [DATA_W-1:0]            in_data_b,
  input  logic [ROB_IDX_W-1:0]         in_rob_idx,
  input  logic [EXC_W-1:0]             in_exception_vector,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data_a,
  output logic [DATA_W-1:0]            out_data_b,
  output logic [ROB_IDX_W-1:0]         out_rob_idx,
  output logic [EXC_W-1:0]             out_exception_vector,
  output logic                         out_has_exception,
  input  logic [ROB_IDX_W-1:0]         rob_head,
  input  logic                         flush_valid,
  input  logic [ROB_IDX_W-1:0]         flush_rob_idx,
  input  logic                         flush_all,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int ENTRY_W = 2*DATA_W + ROB_IDX_W + EXC_W;
  localparam int OCC_W   = $clog2(STAGES+1);
  // Field positions inside the flat entry {a, b, rob_idx, exc}.
  localparam int ROB_LSB = EXC_W;
  localparam int B_LSB   = EXC_W + ROB_IDX_W;
  localparam int A_LSB   = B_LSB + DATA_W;

  // True when idx is strictly younger than the flushing instruction.
  function automatic logic is_younger(
    input logic                 fl_valid,
    input logic [ROB_IDX_W-1:0] idx,
    input logic [ROB_IDX_W-1:0] fl_idx,
    input logic [ROB_IDX_W-1:0] head
  );
    logic [EXEX_ROB_MAX_W-1:0] idx_ext;
    logic [EXEX_ROB_MAX_W-1:0] fl_ext;
    logic [EXEX_ROB_MAX_W-1:0] head_ext;
    idx_ext  = '0;
    fl_ext   = '0;
    head_ext = '0;
    idx_ext[ROB_IDX_W-1:0]  = idx;
    fl_ext[ROB_IDX_W-1:0]   = fl_idx;
    head_ext[ROB_IDX_W-1:0] = head;
    return fl_valid &&
           (rob_age(idx_ext, head_ext, unsigned'(ROB_IDX_W)) >
            rob_age(fl_ext, head_ext, unsigned'(ROB_IDX_W)));
  endfunction

  logic [STAGES-1:0]  valid;
  logic [STAGES-1:0]  ready;       // stage may take its incoming slot
  logic [STAGES-1:0]  inc_valid;   // valid of the slot feeding each stage
  logic [STAGES-1:0]  kill_held;
  logic [STAGES-1:0]  kill_inc;
  logic [ENTRY_W-1:0] entry     [STAGES];
  logic [ENTRY_W-1:0] inc_entry [STAGES];

`ifndef EXEX_BUBBLE_COLLAPSE_EN
  logic stall;
  assign stall    = valid[STAGES-1] && !out_ready;
  assign in_ready = !stall;
`else
  assign in_ready = ready[0];
`endif

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_src_in
        assign inc_valid[gi] = in_valid;
        assign inc_entry[gi] = {in_data_a, in_data_b, in_rob_idx, in_exception_vector};
      end else begin : g_src_prev
        assign inc_valid[gi] = valid[gi-1];
        assign inc_entry[gi] = entry[gi-1];
      end

`ifdef EXEX_BUBBLE_COLLAPSE_EN
      // A stage can take a new slot if it is empty or its own entry leaves.
      if (gi == STAGES-1) begin : g_rdy_last
        assign ready[gi] = !valid[gi] || out_ready;
      end else begin : g_rdy_mid
        assign ready[gi] = !valid[gi] || ready[gi+1];
      end
`else
      // Global stall: the chain shifts as a whole, bubbles included.
      assign ready[gi] = !stall;
`endif

      assign kill_held[gi] = flush_all ||
        is_younger(flush_valid, entry[gi][ROB_LSB +: ROB_IDX_W], flush_rob_idx, rob_head);
      assign kill_inc[gi] =
        is_younger(flush_valid, inc_entry[gi][ROB_LSB +: ROB_IDX_W], flush_rob_idx, rob_head);

      exex_stage #(
        .ENTRY_W(ENTRY_W)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .load      (ready[gi]),
        .load_valid(inc_valid[gi] && !flush_all && !kill_inc[gi]),
        .capture   (ready[gi] && inc_valid[gi] && !flush_all),
        .kill      (kill_held[gi]),
        .in_entry  (inc_entry[gi]),
        .valid     (valid[gi]),
        .entry     (entry[gi])
      );
    end
  endgenerate

  assign out_valid            = valid[STAGES-1];
  assign out_data_a           = entry[STAGES-1][A_LSB +: DATA_W];
  assign out_data_b           = entry[STAGES-1][B_LSB +: DATA_W];
  assign out_rob_idx          = entry[STAGES-1][ROB_LSB +: ROB_IDX_W];
  assign out_exception_vector = entry[STAGES-1][0 +: EXC_W];
  assign out_has_exception    = out_valid && (|entry[STAGES-1][0 +: EXC_W]);

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(valid[i]);
    end
  end

endmodule

// File: tb/tb_exex_pipe.sv
// tb_exex_pipe: self-checking bench for exex_pipe (STAGES=3, default widths).
// A queue of in-flight entries models the pipe: accepted entries are appended,
// flushed ones removed by ROB age, deliveries must match the queue head, and
// occupancy must equal the queue length every cycle.
module tb_exex_pipe;
  import exex_pkg::*;

  localparam int STAGES    = 3;
  localparam int DATA_W    = 32;
  localparam int ROB_IDX_W = 4;
  localparam int EXC_W     = 3;
  localparam int ROB_DEPTH = 1 << ROB_IDX_W;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data_a;
  logic [DATA_W-1:0]    in_data_b;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic [EXC_W-1:0]     in_exception_vector;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data_a;
  logic [DATA_W-1:0]    out_data_b;
  logic [ROB_IDX_W-1:0] out_rob_idx;
  logic [EXC_W-1:0]     out_exception_vector;
  logic                 out_has_exception;
  logic [ROB_IDX_W-1:0] rob_head;
  logic                 flush_valid;
  logic [ROB_IDX_W-1:0] flush_rob_idx;
  logic                 flush_all;
  logic [1:0]           occupancy;

  exex_pipe #(
    .DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W), .EXC_W(EXC_W), .STAGES(STAGES)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_a(in_data_a), .in_data_b(in_data_b),
    .in_rob_idx(in_rob_idx), .in_exception_vector(in_exception_vector),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_a(out_data_a), .out_data_b(out_data_b),
    .out_rob_idx(out_rob_idx), .out_exception_vector(out_exception_vector),
    .out_has_exception(out_has_exception),
    .rob_head(rob_head), .flush_valid(flush_valid),
    .flush_rob_idx(flush_rob_idx), .flush_all(flush_all),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  exex_entry_t q[$];
  int          acc_time[$];

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int age(input int x, input int h);
    return ((x - h) % ROB_DEPTH + ROB_DEPTH) % ROB_DEPTH;
  endfunction

  task automatic drive(input bit v, input int idx, input int exc);
    in_valid            = v;
    in_rob_idx          = ROB_IDX_W'(idx);
    in_exception_vector = EXC_W'(exc);
    in_data_a           = $urandom();
    in_data_b           = $urandom();
  endtask

  // One clock: sample handshakes mid-cycle, update model, check after edge.
  task automatic step();
    bit          acc;
    bit          del;
    exex_entry_t f;
    exex_entry_t inc;
    int          t;
    @(negedge clk);
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    if (!out_valid) check("has_exc_idle", 64'(out_has_exception), 64'(0));
    if (del) begin
      check("model_nonempty", 64'(q.size() == 0), 64'(0));
      if (q.size() > 0) begin
        f = q.pop_front();
        t = acc_time.pop_front();
        check("out_rob_idx", 64'(out_rob_idx), 64'(f.rob_idx));
        check("out_data_a", 64'(out_data_a), 64'(f.data_a));
        check("out_data_b", 64'(out_data_b), 64'(f.data_b));
        check("out_exc", 64'(out_exception_vector), 64'(f.exception_vector));
        check("out_has_exc", 64'(out_has_exception), 64'(f.exception_vector != 0));
        if (lat_chk) check("latency", 64'(cyc - t), 64'(STAGES));
      end
    end
    if (flush_all) begin
      q.delete();
      acc_time.delete();
    end else if (flush_valid) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (age(int'(q[i].rob_idx), int'(rob_head)) > age(int'(flush_rob_idx), int'(rob_head))) begin
          q.delete(i);
          acc_time.delete(i);
        end
      end
    end
    if (acc && !flush_all) begin
      inc.data_a           = in_data_a;
      inc.data_b           = in_data_b;
      inc.rob_idx          = in_rob_idx;
      inc.exception_vector = in_exception_vector;
      if (!(flush_valid &&
            age(int'(in_rob_idx), int'(rob_head)) > age(int'(flush_rob_idx), int'(rob_head)))) begin
        q.push_back(inc);
        acc_time.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("occupancy", 64'(occupancy), 64'(q.size()));
  endtask

  task automatic drain();
    in_valid    = 1'b0;
    flush_valid = 1'b0;
    flush_all   = 1'b0;
    out_ready   = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    check("drain_done", 64'(q.size()), 64'(0));
    $display("drain complete at cycle %0d", cyc);
  endtask

  logic [DATA_W-1:0]    snap_a;
  logic [ROB_IDX_W-1:0] snap_idx;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data_a = '0; in_data_b = '0;
    in_rob_idx = '0; in_exception_vector = '0; out_ready = 1'b0;
    rob_head = '0; flush_valid = 1'b0; flush_rob_idx = '0; flush_all = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_out_data_a", 64'(out_data_a), 64'(0));
    check("rst_out_rob_idx", 64'(out_rob_idx), 64'(0));
    check("rst_has_exc", 64'(out_has_exception), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    reset = 1'b0;
    $display("reset checked");

    // Stream of 6 entries, no back-pressure, fixed latency
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i, 0);
      step();
      $display("stream accept idx %0d at cycle %0d", i, cyc);
    end
    drain();
    lat_chk = 1'b0;

    // Fill then stall 4 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6 + i, 0);
      step();
    end
    check("fill_occupancy", 64'(occupancy), 64'(3));
    snap_a   = out_data_a;
    snap_idx = out_rob_idx;
    drive(1'b1, 9, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_hold_a", 64'(out_data_a), 64'(snap_a));
      check("stall_hold_idx", 64'(out_rob_idx), 64'(snap_idx));
      $display("stall cycle %0d occupancy %0d", i, occupancy);
    end
    drain();

    // Bubble between stage 2 and stage 0 with output stalled
    out_ready = 1'b0;
    drive(1'b1, 1, 0); step();
    drive(1'b0, 0, 0); step();
    drive(1'b1, 2, 0); step();
    in_valid = 1'b0;
`ifdef EXEX_BUBBLE_COLLAPSE_EN
    check("bubble_in_ready", 64'(in_ready), 64'(1));
`else
    check("bubble_in_ready", 64'(in_ready), 64'(0));
`endif
    step();
    out_ready = 1'b1;
    step();
`ifdef EXEX_BUBBLE_COLLAPSE_EN
    check("bubble_collapsed", 64'(out_valid), 64'(1));
`else
    check("bubble_collapsed", 64'(out_valid), 64'(0));
`endif
    $display("bubble test out_valid %0d", out_valid);
    drain();

    // Wrap-around selective flush: head=14, entries 15, 0, 2; flush idx 0
    rob_head  = ROB_IDX_W'(14);
    out_ready = 1'b0;
    drive(1'b1, 15, 0); step();
    drive(1'b1, 0, 0);  step();
    drive(1'b1, 2, 0);  step();
    in_valid      = 1'b0;
    flush_valid   = 1'b1;
    flush_rob_idx = '0;
    step();
    flush_valid = 1'b0;
    check("wrap_flush_occupancy", 64'(occupancy), 64'(2));
    $display("wrap flush occupancy %0d", occupancy);
    drain();

    // flush_all with an incoming entry
    out_ready = 1'b0;
    drive(1'b1, 3, 0); step();
    drive(1'b1, 4, 0); step();
    drive(1'b1, 5, 0);
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    in_valid  = 1'b0;
    check("flush_all_occupancy", 64'(occupancy), 64'(0));
    check("flush_all_out_valid", 64'(out_valid), 64'(0));
    step();
    $display("flush_all done occupancy %0d", occupancy);

    // Exception flag follows its entry through the output
    out_ready = 1'b1;
    drive(1'b1, 6, 0);     step();
    drive(1'b1, 7, 3'b100); step();
    drive(1'b1, 8, 0);     step();
    drain();

    // Reset mid-stream
    drive(1'b1, 9, 1);  step();
    drive(1'b1, 10, 2); step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_occupancy", 64'(occupancy), 64'(0));
    check("midrst_out_exc", 64'(out_exception_vector), 64'(0));
    check("midrst_out_data_b", 64'(out_data_b), 64'(0));
    check("midrst_has_exc", 64'(out_has_exception), 64'(0));
    reset = 1'b0;
    q.delete();
    acc_time.delete();
    in_valid = 1'b0;
    step();
    $display("mid-stream reset checked");

    // Randomized traffic with flushes and back-pressure
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, ROB_DEPTH - 1), $urandom_range(0, 7));
      out_ready     = $urandom_range(0, 9) < 7;
      rob_head      = ROB_IDX_W'($urandom_range(0, ROB_DEPTH - 1));
      flush_valid   = $urandom_range(0, 9) == 0;
      flush_rob_idx = ROB_IDX_W'($urandom_range(0, ROB_DEPTH - 1));
      flush_all     = $urandom_range(0, 31) == 0;
      step();
      $display("rand cycle %0d occupancy %0d model %0d", i, occupancy, q.size());
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
